// File: rtl/hall_emulator.sv
// Synthetic three-phase Hall sequence source for BLDC bring-up.
// Programmable step period and direction, with revolution count and illegal-code injection.
module hall_emulator #(
  parameter int CNT_W = 24,
  parameter int REV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             dir,
  input  logic [CNT_W-1:0] period,
  input  logic             inj_fault,
  input  logic             fault_code,
  output logic             Ha,
  output logic             Hb,
  output logic             Hc,
  output logic             step_strobe,
  output logic [2:0]       sector,
  output logic [REV_W-1:0] rev_count,
  output logic             fault_active
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FAULT
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] per, per_n, per_cl;
  logic [2:0]       idx, idx_n, idx_nx;
  logic [2:0]       code, code_n;
  logic             strobe_n, fa_n;
  logic             pend, pend_n;
  logic             fc, fc_n;
  logic [REV_W-1:0] rev_n;
  logic             boundary;

  function automatic logic [2:0] code_of(input logic [2:0] i);
    logic [2:0] c;
    unique case (i)
      3'd0:    c = 3'b100;
      3'd1:    c = 3'b110;
      3'd2:    c = 3'b010;
      3'd3:    c = 3'b011;
      3'd4:    c = 3'b001;
      default: c = 3'b101;
    endcase
    return c;
  endfunction

  // Periods below 2 would make every cycle a boundary
  assign per_cl   = (period < CNT_W'(2)) ? CNT_W'(2) : period;
  assign boundary = (cnt == per - 1'b1);

  always_comb begin
    idx_nx = idx;
    if (dir) idx_nx = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    else     idx_nx = (idx == 3'd0) ? 3'd5 : idx - 3'd1;
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    per_n    = per;
    idx_n    = idx;
    code_n   = code;
    strobe_n = 1'b0;
    fa_n     = fault_active;
    pend_n   = pend;
    fc_n     = fc;
    rev_n    = rev_count;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (enable) begin
          state_n = RUN;
          per_n   = per_cl;
        end
      end
      RUN, FAULT: begin
        if (!enable) begin
          state_n = IDLE;
          cnt_n   = '0;
          pend_n  = 1'b0;
          code_n  = code_of(idx);
          fa_n    = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
          if (state == RUN && !pend && inj_fault) begin
            pend_n = 1'b1;
            fc_n   = fault_code;
          end
          if (boundary) begin
            cnt_n    = '0;
            idx_n    = idx_nx;
            per_n    = per_cl;
            strobe_n = 1'b1;
            if (idx_nx == 3'd0) rev_n = rev_count + 1'b1;
            // A pending fault replaces exactly one legal step
            if (state == RUN && pend) begin
              state_n = FAULT;
              code_n  = {3{fc}};
              fa_n    = 1'b1;
              pend_n  = 1'b0;
            end else begin
              state_n = RUN;
              code_n  = code_of(idx_nx);
              fa_n    = 1'b0;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      per          <= CNT_W'(2);
      idx          <= 3'd0;
      code         <= 3'b100;
      step_strobe  <= 1'b0;
      fault_active <= 1'b0;
      pend         <= 1'b0;
      fc           <= 1'b0;
      rev_count    <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      per          <= per_n;
      idx          <= idx_n;
      code         <= code_n;
      step_strobe  <= strobe_n;
      fault_active <= fa_n;
      pend         <= pend_n;
      fc           <= fc_n;
      rev_count    <= rev_n;
    end
  end

  assign {Ha, Hb, Hc} = code;
  assign sector       = idx;

endmodule
